// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point normalize/round path:
// FSM encoding, format constants, mantissa field positions and flag indices.
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] EXP_MAX = 8'hFF;
    localparam int         BIAS    = 127;

    // Raw mantissa layout: {carry, hidden, frac[22:0], guard, sticky}
    localparam int CARRY_BIT  = 26;
    localparam int HIDDEN_BIT = 25;
    localparam int FRAC_MSB   = 24;
    localparam int FRAC_LSB   = 2;
    localparam int GUARD_BIT  = 1;
    localparam int STICKY_BIT = 0;

    localparam int FLAG_OVF  = 3;
    localparam int FLAG_UNF  = 2;
    localparam int FLAG_INX  = 1;
    localparam int FLAG_ZERO = 0;

    localparam logic [3:0] ZERO_FLAGS = 4'b0001 << FLAG_ZERO;

endpackage

// File: rtl/fp_round.sv
// Combinational round-to-nearest-even incrementer on a normalized (or denormal)
// mantissa; a carry out of the hidden bit renormalizes and bumps the exponent.
module fp_round
    import fp_pkg::*;
(
    input  logic              [25:0] mant,
    input  logic signed       [9:0]  exponent,
    output logic              [23:0] rounded_sig,
    output logic signed       [9:0]  rounded_exp,
    output logic                     inexact,
    output logic                     carry
);

    logic        round_up;
    logic [24:0] sum;

    always_comb begin
        round_up    = mant[GUARD_BIT] & (mant[STICKY_BIT] | mant[FRAC_LSB]);
        inexact     = mant[GUARD_BIT] | mant[STICKY_BIT];
        sum         = {1'b0, mant[HIDDEN_BIT:FRAC_LSB]} + {24'd0, round_up};
        carry       = sum[24];
        // On carry the low bit is necessarily zero, so the right shift is exact.
        rounded_sig = carry ? sum[24:1] : sum[23:0];
        rounded_exp = exponent + $signed({9'd0, carry});
    end

endmodule

// File: rtl/fp_normalizer.sv
// Multi-cycle normalize-and-round stage for the FP add/sub result: one-bit-per-cycle
// left normalization, single right shift on carry-out, RNE rounding, valid/ready out.
module fp_normalizer
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign_in,
    input  logic [7:0]  exp_in,
    input  logic [26:0] mant_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [3:0]  fp_flags
);

    state_t state, next_state;

    logic              sign_q;
    logic signed [9:0] exp_q;
    logic [26:0]       mant_q;

    logic [23:0]       rnd_sig;
    logic signed [9:0] rnd_exp;
    logic              rnd_inexact;
    logic              rnd_carry_unused;
    logic [7:0]        exp_field;
    logic [31:0]       round_result;
    logic [3:0]        round_flags;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (in_valid) next_state = (exp_in == EXP_MAX) ? DONE : SHIFT;
            SHIFT: begin
                if (mant_q == 27'd0)
                    next_state = DONE;
                else if (mant_q[CARRY_BIT] || mant_q[HIDDEN_BIT] || exp_q <= 10'sd1)
                    next_state = ROUND;
            end
            ROUND: next_state = DONE;
            DONE:  if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    fp_round u_round (
        .mant        (mant_q[25:0]),
        .exponent    (exp_q),
        .rounded_sig (rnd_sig),
        .rounded_exp (rnd_exp),
        .inexact     (rnd_inexact),
        .carry       (rnd_carry_unused)
    );

    // Denormals leave SHIFT with exp=1; a clear hidden bit after rounding means field 0.
    always_comb begin
        exp_field             = rnd_sig[23] ? rnd_exp[7:0] : 8'd0;
        round_flags           = '0;
        round_flags[FLAG_INX] = rnd_inexact;
        if (rnd_exp >= 10'sd255) begin
            round_result          = {sign_q, EXP_MAX, 23'd0};
            round_flags[FLAG_OVF] = 1'b1;
            round_flags[FLAG_INX] = 1'b1;
        end else begin
            round_result           = {sign_q, exp_field, rnd_sig[22:0]};
            round_flags[FLAG_UNF]  = (exp_field == 8'd0) && rnd_inexact;
            round_flags[FLAG_ZERO] = (rnd_sig == 24'd0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            result   <= '0;
            fp_flags <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sign_q <= sign_in;
                    exp_q  <= (exp_in == 8'd0) ? 10'sd1 : $signed({2'b00, exp_in});
                    mant_q <= mant_in;
                    if (exp_in == EXP_MAX) begin
                        result   <= {sign_in, EXP_MAX, mant_in[FRAC_MSB:FRAC_LSB]};
                        fp_flags <= '0;
                    end
                end
                SHIFT: begin
                    if (mant_q == 27'd0) begin
                        result   <= {sign_q, 31'd0};
                        fp_flags <= ZERO_FLAGS;
                    end else if (mant_q[CARRY_BIT]) begin
                        mant_q <= {1'b0, mant_q[26:2], mant_q[GUARD_BIT] | mant_q[STICKY_BIT]};
                        exp_q  <= exp_q + 10'sd1;
                    end else if (!mant_q[HIDDEN_BIT] && exp_q > 10'sd1) begin
                        // Sticky stays put; the guard position refills with zero.
                        mant_q <= {1'b0, mant_q[24:1], 1'b0, mant_q[STICKY_BIT]};
                        exp_q  <= exp_q - 10'sd1;
                    end
                end
                ROUND: begin
                    result   <= round_result;
                    fp_flags <= round_flags;
                end
                default: ;
            endcase
        end
    end

endmodule
